trap_sequencer: RTL and testbench
=================================

Name: trap_sequencer

Overview:
Multi-cycle controller that sequences machine-mode trap entry and MRET return for the RV64 core. It sits beside the writeback stage and owns the CSR file's write port during context switches. It prioritises pending exceptions and interrupts and writes mepc, mcause, mtval and mstatus, one CSR per cycle. It then flushes the pipeline and redirects the PC.

Parameters:
XLEN, 64, datapath width
RESET_PRIV, 1, privilege after reset (1 = machine, 0 = user)

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
WB_V  in  1  writeback instruction valid
WB_PC  in  64  PC of the writeback instruction
WB_IR  in  32  writeback instruction word
WB_MRET  in  1  writeback instruction is MRET
EXC_FLAGS  in  8  bit map: [0]F_IAM [1]F_IAF [2]F_II [3]ECALL [4]MEM_LAM [5]MEM_LAF [6]MEM_SAM [7]MEM_SAF
TVAL_IN  in  64  faulting address for fetch and memory faults
TIMER  in  1  machine timer interrupt pending
EXTERNAL  in  1  machine external interrupt pending
MSTATUS_IN  in  64  current mstatus
MTVEC_IN  in  64  current mtvec
MEPC_IN  in  64  current mepc
CSR_WE  out  1  CSR write strobe
CSR_ADDR  out  12  CSR write address
CSR_WDATA  out  64  CSR write data
FLUSH  out  1  squash all pipeline stages
STALL  out  1  freeze fetch and decode
PC_REDIRECT  out  1  load PC from REDIRECT_TARGET
REDIRECT_TARGET  out  64  new PC
PRIV_OUT  out  1  current privilege (1 = M, 0 = U)
BUSY  out  1  sequencer not in IDLE

Behaviour:
- FSM states: IDLE, W_MEPC, W_MCAUSE, W_MTVAL, W_MSTATUS, REDIR, R_MSTATUS.
- All outputs are Moore, decoded from state and the latched registers.
- Reset is immediate and asynchronous:
  - state goes to IDLE; every output is 0 except PRIV_OUT = RESET_PRIV.
  - latched cause, epc and tval clear to 0.
  - reset during any state abandons the sequence; no further CSR writes occur.
- IDLE sampling: evaluated only when WB_V = 1; with WB_V = 0 the FSM stays in IDLE.
- Exception priority, highest first: F_IAF(1), F_II(2), F_IAM(0), ECALL, MEM_SAM(6), MEM_LAM(4), MEM_SAF(7), MEM_LAF(5).
- ECALL cause code: 11 if PRIV_OUT = 1, else 8.
- Interrupts are eligible only if MSTATUS_IN[3] (MIE) = 1 and no exception flag is set. EXTERNAL (cause 11) wins over TIMER (cause 7). The latched cause has bit63 = 1.
- Any exception beats any interrupt. A trap beats WB_MRET.
- Trap accepted on a posedge → latch:
  - epc = WB_PC.
  - cause as above.
  - tval = TVAL_IN for codes 0, 1, 4, 5, 6, 7; zero-extended WB_IR for code 2; 0 otherwise.
  - next state W_MEPC.
- WB_MRET accepted (no trap) → R_MSTATUS.
- One CSR write per state, CSR_WE = 1 for exactly one cycle each:
  - W_MEPC: CSR_ADDR 0x341, CSR_WDATA = {epc[63:2], 2'b00}.
  - W_MCAUSE: CSR_ADDR 0x342, CSR_WDATA = cause.
  - W_MTVAL: CSR_ADDR 0x343, CSR_WDATA = tval.
  - W_MSTATUS: CSR_ADDR 0x300, CSR_WDATA = MSTATUS_IN with MPIE[7] = MIE[3], MIE[3] = 0, MPP[12:11] = {2{PRIV_OUT}}. PRIV_OUT becomes 1 at the end of this state.
  - R_MSTATUS: CSR_ADDR 0x300, CSR_WDATA = MSTATUS_IN with MIE = MPIE, MPIE = 1, MPP = 00. PRIV_OUT becomes (MPP != 0) at the end of this state.
- REDIR: PC_REDIRECT = 1 for one cycle, then IDLE.
  - Trap target: {MTVEC_IN[63:2], 2'b00} when MTVEC_IN[1:0] = 00 or the trap is an exception.
  - Vectored interrupt target (mode 01): base + 4 × cause[5:0].
  - MRET target: MEPC_IN.
  - MTVEC_IN[1:0] ≥ 10 is treated as direct mode.
- FLUSH, STALL and BUSY are 1 in every non-IDLE state.
- Latency:
  - Trap: 5 busy cycles after the accepting edge; PC_REDIRECT in the 5th.
  - MRET: 2 busy cycles.
- All trap, MRET and WB inputs are ignored while BUSY; they are not queued.
- An interrupt raised and dropped within a single BUSY window is lost. This is acceptable because interrupt sources are level-held.

Test Plan:
- Illegal instruction: WB_V = 1, EXC_FLAGS = 8'h04, WB_PC = 0x1000, WB_IR = 0xFFFFFFFF, MTVEC_IN = 0x8000 → writes 0x341 = 0x1000, 0x342 = 2, 0x343 = 0xFFFFFFFF, then 0x300; PC_REDIRECT with target 0x8000 in the 5th cycle.
- Exception and interrupt together: EXC_FLAGS = 8'h20, TVAL_IN = 0x2003, TIMER = 1, MIE = 1 → mcause = 5, mtval = 0x2003; the timer is not taken. Once IDLE is reached with TIMER still high, a second trap follows with mcause = 0x8000000000000007.
- Vectored interrupt: MTVEC_IN = 0x8001, EXTERNAL = 1, MIE = 1 → target = 0x8000 + 44 = 0x802C, mcause bit63 = 1. With MIE = 0 → no trap, BUSY stays 0.
- ECALL then MRET:
  - From user mode (PRIV_OUT = 0): ECALL → mcause = 8, mstatus MPP = 00, PRIV_OUT → 1.
  - MRET with MSTATUS_IN[7] = 1, MEPC_IN = 0x1004 → mstatus MIE = 1, MPIE = 1; PRIV_OUT → 0; target 0x1004 after 2 cycles.
- Reset mid-sequence: assert RESET in W_MTVAL → CSR_WE, FLUSH and BUSY drop to 0 asynchronously (before the next edge); after release the FSM is in IDLE and no 0x300 write occurs.
- WB_V = 0 with EXC_FLAGS = 8'hFF and TIMER = 1 → no state change for 10 cycles.

Source files
------------

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer: latches trap context from writeback,
// streams mepc/mcause/mtval/mstatus through the CSR write port, then redirects the PC.
module trap_sequencer #(
    parameter int XLEN       = 64,
    parameter bit RESET_PRIV = 1'b1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            WB_V,
    input  logic [XLEN-1:0] WB_PC,
    input  logic [31:0]     WB_IR,
    input  logic            WB_MRET,
    input  logic [7:0]      EXC_FLAGS,
    input  logic [XLEN-1:0] TVAL_IN,
    input  logic            TIMER,
    input  logic            EXTERNAL,
    input  logic [XLEN-1:0] MSTATUS_IN,
    input  logic [XLEN-1:0] MTVEC_IN,
    input  logic [XLEN-1:0] MEPC_IN,
    output logic            CSR_WE,
    output logic [11:0]     CSR_ADDR,
    output logic [XLEN-1:0] CSR_WDATA,
    output logic            FLUSH,
    output logic            STALL,
    output logic            PC_REDIRECT,
    output logic [XLEN-1:0] REDIRECT_TARGET,
    output logic            PRIV_OUT,
    output logic            BUSY
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        W_MEPC    = 3'd1,
        W_MCAUSE  = 3'd2,
        W_MTVAL   = 3'd3,
        W_MSTATUS = 3'd4,
        REDIR     = 3'd5,
        R_MSTATUS = 3'd6
    } state_t;

    localparam logic [XLEN-1:0] INTR_BIT = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state_q, state_d;
    logic [XLEN-1:0] cause_q, cause_d;
    logic [XLEN-1:0] epc_q, epc_d;
    logic [XLEN-1:0] tval_q, tval_d;
    logic            priv_q, priv_d;
    logic            mret_q, mret_d;

    logic            exc_any;
    logic [3:0]      exc_code;
    logic            intr_take;
    logic [3:0]      intr_code;
    logic [XLEN-1:0] trap_mstatus;
    logic [XLEN-1:0] mret_mstatus;
    logic [XLEN-1:0] tvec_base;
    logic [XLEN-1:0] trap_target;

    // Fixed exception priority chain; ECALL code depends on the current privilege.
    always_comb begin
        exc_code = 4'd0;
        if (EXC_FLAGS[1])      exc_code = 4'd1;
        else if (EXC_FLAGS[2]) exc_code = 4'd2;
        else if (EXC_FLAGS[0]) exc_code = 4'd0;
        else if (EXC_FLAGS[3]) exc_code = priv_q ? 4'd11 : 4'd8;
        else if (EXC_FLAGS[6]) exc_code = 4'd6;
        else if (EXC_FLAGS[4]) exc_code = 4'd4;
        else if (EXC_FLAGS[7]) exc_code = 4'd7;
        else if (EXC_FLAGS[5]) exc_code = 4'd5;
    end

    assign exc_any   = |EXC_FLAGS;
    assign intr_take = !exc_any && MSTATUS_IN[3] && (TIMER || EXTERNAL);
    assign intr_code = EXTERNAL ? 4'd11 : 4'd7;

    always_comb begin
        trap_mstatus        = MSTATUS_IN;
        trap_mstatus[7]     = MSTATUS_IN[3];
        trap_mstatus[3]     = 1'b0;
        trap_mstatus[12:11] = {2{priv_q}};
        mret_mstatus        = MSTATUS_IN;
        mret_mstatus[3]     = MSTATUS_IN[7];
        mret_mstatus[7]     = 1'b1;
        mret_mstatus[12:11] = 2'b00;
    end

    // Only interrupts honour vectored mode; modes 10/11 fall back to direct.
    assign tvec_base   = {MTVEC_IN[XLEN-1:2], 2'b00};
    assign trap_target = (cause_q[XLEN-1] && (MTVEC_IN[1:0] == 2'b01))
                       ? tvec_base + XLEN'({cause_q[5:0], 2'b00})
                       : tvec_base;

    always_comb begin
        state_d         = state_q;
        cause_d         = cause_q;
        epc_d           = epc_q;
        tval_d          = tval_q;
        priv_d          = priv_q;
        mret_d          = mret_q;
        CSR_WE          = 1'b0;
        CSR_ADDR        = 12'h000;
        CSR_WDATA       = '0;
        PC_REDIRECT     = 1'b0;
        REDIRECT_TARGET = '0;
        BUSY            = (state_q != IDLE);
        FLUSH           = (state_q != IDLE);
        STALL           = (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (WB_V) begin
                    if (exc_any || intr_take) begin
                        epc_d   = WB_PC;
                        mret_d  = 1'b0;
                        state_d = W_MEPC;
                        if (exc_any) begin
                            cause_d = XLEN'(exc_code);
                            case (exc_code)
                                4'd0, 4'd1, 4'd4,
                                4'd5, 4'd6, 4'd7: tval_d = TVAL_IN;
                                4'd2:             tval_d = XLEN'(WB_IR);
                                default:          tval_d = '0;
                            endcase
                        end else begin
                            cause_d = INTR_BIT | XLEN'(intr_code);
                            tval_d  = '0;
                        end
                    end else if (WB_MRET) begin
                        mret_d  = 1'b1;
                        state_d = R_MSTATUS;
                    end
                end
            end
            W_MEPC: begin
                CSR_WE    = 1'b1;
                CSR_ADDR  = 12'h341;
                CSR_WDATA = {epc_q[XLEN-1:2], 2'b00};
                state_d   = W_MCAUSE;
            end
            W_MCAUSE: begin
                CSR_WE    = 1'b1;
                CSR_ADDR  = 12'h342;
                CSR_WDATA = cause_q;
                state_d   = W_MTVAL;
            end
            W_MTVAL: begin
                CSR_WE    = 1'b1;
                CSR_ADDR  = 12'h343;
                CSR_WDATA = tval_q;
                state_d   = W_MSTATUS;
            end
            W_MSTATUS: begin
                CSR_WE    = 1'b1;
                CSR_ADDR  = 12'h300;
                CSR_WDATA = trap_mstatus;
                priv_d    = 1'b1;
                state_d   = REDIR;
            end
            R_MSTATUS: begin
                CSR_WE    = 1'b1;
                CSR_ADDR  = 12'h300;
                CSR_WDATA = mret_mstatus;
                priv_d    = (MSTATUS_IN[12:11] != 2'b00);
                state_d   = REDIR;
            end
            REDIR: begin
                PC_REDIRECT     = 1'b1;
                REDIRECT_TARGET = mret_q ? MEPC_IN : trap_target;
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign PRIV_OUT = priv_q;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= IDLE;
            cause_q <= '0;
            epc_q   <= '0;
            tval_q  <= '0;
            priv_q  <= RESET_PRIV;
            mret_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
            tval_q  <= tval_d;
            priv_q  <= priv_d;
            mret_q  <= mret_d;
        end
    end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: trap/MRET sequences, priority, vectoring,
// asynchronous reset mid-sequence and WB_V gating.
module tb_trap_sequencer;

    logic        CLK;
    logic        RESET;
    logic        WB_V;
    logic [63:0] WB_PC;
    logic [31:0] WB_IR;
    logic        WB_MRET;
    logic [7:0]  EXC_FLAGS;
    logic [63:0] TVAL_IN;
    logic        TIMER;
    logic        EXTERNAL;
    logic [63:0] MSTATUS_IN;
    logic [63:0] MTVEC_IN;
    logic [63:0] MEPC_IN;
    logic        CSR_WE;
    logic [11:0] CSR_ADDR;
    logic [63:0] CSR_WDATA;
    logic        FLUSH;
    logic        STALL;
    logic        PC_REDIRECT;
    logic [63:0] REDIRECT_TARGET;
    logic        PRIV_OUT;
    logic        BUSY;

    int checks = 0;
    int errors = 0;

    logic        obs_we    [8];
    logic [11:0] obs_addr  [8];
    logic [63:0] obs_data  [8];
    logic        obs_redir [8];
    logic [63:0] obs_tgt   [8];
    logic        obs_busy  [8];
    logic        obs_priv  [8];

    trap_sequencer #(.XLEN(64), .RESET_PRIV(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .WB_V(WB_V), .WB_PC(WB_PC), .WB_IR(WB_IR),
        .WB_MRET(WB_MRET), .EXC_FLAGS(EXC_FLAGS), .TVAL_IN(TVAL_IN), .TIMER(TIMER),
        .EXTERNAL(EXTERNAL), .MSTATUS_IN(MSTATUS_IN), .MTVEC_IN(MTVEC_IN),
        .MEPC_IN(MEPC_IN), .CSR_WE(CSR_WE), .CSR_ADDR(CSR_ADDR), .CSR_WDATA(CSR_WDATA),
        .FLUSH(FLUSH), .STALL(STALL), .PC_REDIRECT(PC_REDIRECT),
        .REDIRECT_TARGET(REDIRECT_TARGET), .PRIV_OUT(PRIV_OUT), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Records outputs at n consecutive falling edges, starting now.
    task automatic observe(input int n);
        for (int i = 0; i < n; i++) begin
            obs_we[i]    = CSR_WE;
            obs_addr[i]  = CSR_ADDR;
            obs_data[i]  = CSR_WDATA;
            obs_redir[i] = PC_REDIRECT;
            obs_tgt[i]   = REDIRECT_TARGET;
            obs_busy[i]  = BUSY && FLUSH && STALL;
            obs_priv[i]  = PRIV_OUT;
            @(negedge CLK);
        end
    endtask

    task automatic idle_inputs;
        WB_V = 1'b0; WB_MRET = 1'b0; EXC_FLAGS = 8'h00; TIMER = 1'b0; EXTERNAL = 1'b0;
    endtask

    task automatic test_reset;
        RESET = 1'b1;
        idle_inputs();
        WB_PC = '0; WB_IR = '0; TVAL_IN = '0; MSTATUS_IN = '0; MTVEC_IN = '0; MEPC_IN = '0;
        repeat (2) @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || FLUSH !== 1'b0 || STALL !== 1'b0 || CSR_WE !== 1'b0 ||
            PC_REDIRECT !== 1'b0 || CSR_ADDR !== 12'h000 || CSR_WDATA !== 64'h0 ||
            REDIRECT_TARGET !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b flush=%b stall=%b we=%b redir=%b addr=%h wdata=%h tgt=%h, required all 0",
                     BUSY, FLUSH, STALL, CSR_WE, PC_REDIRECT, CSR_ADDR, CSR_WDATA, REDIRECT_TARGET);
        end
        checks++;
        if (PRIV_OUT !== 1'b1) begin
            errors++;
            $display("FAIL reset_priv: got %b required 1", PRIV_OUT);
        end
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_illegal;
        logic [11:0] ea [4];
        logic [63:0] ed [4];
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{64'h1000, 64'd2, 64'hFFFF_FFFF, 64'h1880};
        @(negedge CLK);
        WB_V = 1'b1; EXC_FLAGS = 8'h04; WB_PC = 64'h1000; WB_IR = 32'hFFFF_FFFF;
        MTVEC_IN = 64'h8000; MSTATUS_IN = 64'h8; TVAL_IN = 64'h1234;
        @(negedge CLK);
        idle_inputs();
        observe(5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_we[i] !== 1'b1 || obs_addr[i] !== ea[i] || obs_data[i] !== ed[i] ||
                obs_busy[i] !== 1'b1 || obs_redir[i] !== 1'b0) begin
                errors++;
                $display("FAIL illegal_csr%0d: we=%b addr=%h data=%h busy=%b, required addr=%h data=%h",
                         i, obs_we[i], obs_addr[i], obs_data[i], obs_busy[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (obs_redir[4] !== 1'b1 || obs_we[4] !== 1'b0 || obs_tgt[4] !== 64'h8000 || obs_busy[4] !== 1'b1) begin
            errors++;
            $display("FAIL illegal_redirect: redir=%b we=%b tgt=%h, required redir=1 we=0 tgt=8000",
                     obs_redir[4], obs_we[4], obs_tgt[4]);
        end
        checks++;
        if (BUSY !== 1'b0 || PRIV_OUT !== 1'b1) begin
            errors++;
            $display("FAIL illegal_done: busy=%b priv=%b, required busy=0 priv=1", BUSY, PRIV_OUT);
        end
    endtask

    task automatic test_exc_and_intr;
        logic [11:0] ea [4];
        logic [63:0] ed [4];
        logic [63:0] e2 [4];
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{64'h2000, 64'd5, 64'h2003, 64'h1880};
        e2 = '{64'h2004, 64'h8000_0000_0000_0007, 64'h0, 64'h1880};
        @(negedge CLK);
        WB_V = 1'b1; EXC_FLAGS = 8'h20; TVAL_IN = 64'h2003; TIMER = 1'b1;
        WB_PC = 64'h2000; MSTATUS_IN = 64'h8; MTVEC_IN = 64'h8000;
        @(negedge CLK);
        EXC_FLAGS = 8'h00; WB_PC = 64'h2004;
        observe(5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_we[i] !== 1'b1 || obs_addr[i] !== ea[i] || obs_data[i] !== ed[i]) begin
                errors++;
                $display("FAIL exc_first_csr%0d: we=%b addr=%h data=%h, required addr=%h data=%h",
                         i, obs_we[i], obs_addr[i], obs_data[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (obs_redir[4] !== 1'b1 || obs_tgt[4] !== 64'h8000 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL exc_first_end: redir=%b tgt=%h busy_after=%b, required 1/8000/0",
                     obs_redir[4], obs_tgt[4], BUSY);
        end
        @(negedge CLK);
        WB_V = 1'b0; TIMER = 1'b0;
        observe(5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_we[i] !== 1'b1 || obs_addr[i] !== ea[i] || obs_data[i] !== e2[i]) begin
                errors++;
                $display("FAIL timer_csr%0d: we=%b addr=%h data=%h, required addr=%h data=%h",
                         i, obs_we[i], obs_addr[i], obs_data[i], ea[i], e2[i]);
            end
        end
        checks++;
        if (obs_redir[4] !== 1'b1 || obs_tgt[4] !== 64'h8000) begin
            errors++;
            $display("FAIL timer_redirect: redir=%b tgt=%h, required 1/8000", obs_redir[4], obs_tgt[4]);
        end
    endtask

    task automatic test_vectored;
        logic [11:0] ea [4];
        logic [63:0] ed [4];
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{64'h3000, 64'h8000_0000_0000_000B, 64'h0, 64'h1880};
        @(negedge CLK);
        WB_V = 1'b1; EXTERNAL = 1'b1; TIMER = 1'b1; MSTATUS_IN = 64'h8;
        MTVEC_IN = 64'h8001; WB_PC = 64'h3000;
        @(negedge CLK);
        idle_inputs();
        observe(5);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_we[i] !== 1'b1 || obs_addr[i] !== ea[i] || obs_data[i] !== ed[i]) begin
                errors++;
                $display("FAIL vec_csr%0d: we=%b addr=%h data=%h, required addr=%h data=%h",
                         i, obs_we[i], obs_addr[i], obs_data[i], ea[i], ed[i]);
            end
        end
        checks++;
        if (obs_redir[4] !== 1'b1 || obs_tgt[4] !== 64'h802C) begin
            errors++;
            $display("FAIL vec_target: redir=%b tgt=%h, required 1/802c", obs_redir[4], obs_tgt[4]);
        end
        WB_V = 1'b1; EXTERNAL = 1'b1; MSTATUS_IN = 64'h0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b0 || CSR_WE !== 1'b0) begin
                errors++;
                $display("FAIL vec_mie_off%0d: busy=%b we=%b, required 0/0", i, BUSY, CSR_WE);
            end
        end
        idle_inputs();
        MTVEC_IN = 64'h8000;
    endtask

    task automatic test_ecall_mret;
        logic [11:0] ea [4];
        logic [63:0] ed [4];
        ea = '{12'h341, 12'h342, 12'h343, 12'h300};
        ed = '{64'h4000, 64'd8, 64'h0, 64'h80};
        for (int r = 0; r < 2; r++) begin
            @(negedge CLK);
            WB_V = 1'b1; WB_MRET = 1'b1; MSTATUS_IN = 64'h80; MEPC_IN = 64'h1004;
            @(negedge CLK);
            idle_inputs();
            observe(2);
            checks++;
            if (obs_we[0] !== 1'b1 || obs_addr[0] !== 12'h300 || obs_data[0] !== 64'h88 || obs_busy[0] !== 1'b1) begin
                errors++;
                $display("FAIL mret%0d_mstatus: we=%b addr=%h data=%h, required 300/88", r, obs_we[0], obs_addr[0], obs_data[0]);
            end
            checks++;
            if (obs_redir[1] !== 1'b1 || obs_tgt[1] !== 64'h1004 || obs_we[1] !== 1'b0 ||
                BUSY !== 1'b0 || PRIV_OUT !== 1'b0) begin
                errors++;
                $display("FAIL mret%0d_redirect: redir=%b tgt=%h busy=%b priv=%b, required 1/1004/0/0",
                         r, obs_redir[1], obs_tgt[1], BUSY, PRIV_OUT);
            end
            if (r == 0) begin
                @(negedge CLK);
                WB_V = 1'b1; EXC_FLAGS = 8'h08; WB_PC = 64'h4000; TVAL_IN = 64'hDEAD;
                MSTATUS_IN = 64'h8; MTVEC_IN = 64'h8000;
                @(negedge CLK);
                idle_inputs();
                observe(5);
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (obs_we[i] !== 1'b1 || obs_addr[i] !== ea[i] || obs_data[i] !== ed[i]) begin
                        errors++;
                        $display("FAIL ecall_csr%0d: we=%b addr=%h data=%h, required addr=%h data=%h",
                                 i, obs_we[i], obs_addr[i], obs_data[i], ea[i], ed[i]);
                    end
                end
                checks++;
                if (obs_priv[0] !== 1'b0 || PRIV_OUT !== 1'b1 || obs_tgt[4] !== 64'h8000) begin
                    errors++;
                    $display("FAIL ecall_priv: priv_before=%b priv_after=%b tgt=%h, required 0/1/8000",
                             obs_priv[0], PRIV_OUT, obs_tgt[4]);
                end
            end
        end
    endtask

    task automatic test_priority;
        logic [7:0]  flags [8];
        logic [63:0] code  [8];
        flags = '{8'hFF, 8'h59, 8'h0C, 8'hD8, 8'hD0, 8'hB0, 8'hA0, 8'h20};
        code  = '{64'd1, 64'd0, 64'd2, 64'd11, 64'd6, 64'd4, 64'd7, 64'd5};
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            WB_V = 1'b1; WB_MRET = 1'b1; EXC_FLAGS = flags[k]; TIMER = 1'b1; EXTERNAL = 1'b1;
            MSTATUS_IN = 64'h8; WB_PC = 64'h5000; MTVEC_IN = 64'h8001;
            @(negedge CLK);
            idle_inputs();
            observe(5);
            checks++;
            if (obs_addr[0] !== 12'h341 || obs_data[1] !== code[k] || obs_redir[4] !== 1'b1 ||
                obs_tgt[4] !== 64'h8000) begin
                errors++;
                $display("FAIL prio_%h: addr0=%h cause=%h redir=%b tgt=%h, required 341/%h/1/8000",
                         flags[k], obs_addr[0], obs_data[1], obs_redir[4], obs_tgt[4], code[k]);
            end
        end
        MTVEC_IN = 64'h8000;
    endtask

    task automatic test_reset_mid;
        @(negedge CLK);
        WB_V = 1'b1; EXC_FLAGS = 8'h04; WB_PC = 64'h6000; MSTATUS_IN = 64'h8;
        @(negedge CLK);
        idle_inputs();
        repeat (2) @(negedge CLK);
        checks++;
        if (CSR_WE !== 1'b1 || CSR_ADDR !== 12'h343) begin
            errors++;
            $display("FAIL rstmid_in_mtval: we=%b addr=%h, required 1/343", CSR_WE, CSR_ADDR);
        end
        #2 RESET = 1'b1;
        #1;
        checks++;
        if (CSR_WE !== 1'b0 || FLUSH !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_async: we=%b flush=%b busy=%b, required 0/0/0", CSR_WE, FLUSH, BUSY);
        end
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (CSR_WE !== 1'b0 || BUSY !== 1'b0 || PRIV_OUT !== 1'b1) begin
                errors++;
                $display("FAIL rstmid_after%0d: we=%b addr=%h busy=%b priv=%b, required 0/-/0/1",
                         i, CSR_WE, CSR_ADDR, BUSY, PRIV_OUT);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_wbv_low;
        @(negedge CLK);
        WB_V = 1'b0; EXC_FLAGS = 8'hFF; TIMER = 1'b1; WB_MRET = 1'b1; MSTATUS_IN = 64'h8;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            checks++;
            if (BUSY !== 1'b0 || CSR_WE !== 1'b0 || PC_REDIRECT !== 1'b0) begin
                errors++;
                $display("FAIL wbv_low%0d: busy=%b we=%b redir=%b, required 0/0/0", i, BUSY, CSR_WE, PC_REDIRECT);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_exc_and_intr();
        test_vectored();
        test_ecall_mret();
        test_priority();
        test_reset_mid();
        test_wbv_low();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
